memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage that consumes the execute-stage result bundle and performs loads and stores to data memory.
- Drives a single-outstanding req/ack data bus and stalls execute while a transaction is open.
- Aligns, sign- or zero-extends load data, and forwards register-write information to writeback.
- Non-memory instructions pass through with one register stage.

Parameters:
- DWIDTH, 32, data/address width
- AWIDTH, 5, register index width
- FUNCT_WIDTH, 3, funct3 width
- TIMEOUT, 16, max BUSY cycles without ack before abort (2..255)

Ports:
- mem_clk  in  1  clock; all state updates on rising edge
- mem_rst  in  1  synchronous, active-high reset
- mem_i_ce  in  1  valid instruction from execute
- mem_i_opcode  in  `OPCODE_WIDTH  opcode from execute
- mem_i_funct3  in  FUNCT_WIDTH  access size/sign
- mem_i_alu_value  in  DWIDTH  effective address (load/store) or result (others)
- mem_i_data_rs2  in  DWIDTH  store data
- mem_i_addr_rd  in  AWIDTH  destination register
- mem_i_wb_en  in  1  execute's register-write request (non-memory ops)
- mem_i_flush  in  1  suppress capture of the current input
- mem_i_stall  in  1  writeback cannot accept a new result
- mem_o_stall  out  1  hold execute
- mem_o_req  out  1  bus request
- mem_o_wr  out  1  1=store, 0=load
- mem_o_addr  out  DWIDTH  word-aligned bus address
- mem_o_wdata  out  DWIDTH  lane-replicated store data
- mem_o_byte_en  out  4  byte lane enables
- mem_i_ack  in  1  bus completion
- mem_i_rdata  in  DWIDTH  load word, valid with ack
- mem_o_ce  out  1  result valid to writeback
- mem_o_addr_rd  out  AWIDTH  destination register
- mem_o_data_rd  out  DWIDTH  writeback data
- mem_o_we_rd  out  1  register write enable
- mem_o_misaligned  out  1  one-cycle pulse: misaligned access dropped
- mem_o_bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE.
  - Timeout counter is 0.
- States:
  - IDLE, BUSY, HOLD.
  - mem_o_stall = (state != IDLE), decoded from registered state.
- Capture:
  - Occurs in IDLE when mem_i_ce=1, !mem_i_flush and !mem_i_stall.
  - Otherwise mem_o_ce goes to 0 next cycle and all other outputs hold.
- Non-memory op captured at T:
  - At T+1: mem_o_ce=1, mem_o_data_rd=mem_i_alu_value, mem_o_we_rd=mem_i_wb_en.
- Load/store captured at T, aligned:
  - State goes to BUSY.
  - At T+1: mem_o_req=1 and mem_o_addr={addr[31:2],2'b00}.
  - mem_o_wr, mem_o_wdata and mem_o_byte_en are held stable until the transaction ends.
  - mem_o_ce=0 while BUSY.
- Misalignment:
  - Misaligned cases: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Misaligned ops issue no request.
  - At T+1: mem_o_misaligned=1 and mem_o_ce=0.
  - State stays IDLE.
- Lanes:
  - SB: byte_en=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: byte_en=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW: byte_en=1111.
  - Loads: byte_en=1111. The selected lane is extended: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Unknown funct3 is treated as word.
- Ack:
  - Ack is sampled only while mem_o_req=1. Ack with req=0 is ignored.
  - On ack at cycle A with !mem_i_stall, at A+1:
    - req=0, state IDLE.
    - mem_o_ce=1.
    - mem_o_we_rd=1 for load, 0 for store.
    - mem_o_data_rd = extended load data (store: unchanged).
  - On ack with mem_i_stall=1: req drops at A+1, state goes to HOLD, extended data is latched.
  - HOLD exits at the first cycle with mem_i_stall=0; the result is presented the next cycle.
- Timeout:
  - Counter increments each BUSY cycle without ack.
  - At TIMEOUT consecutive cycles: req=0, state IDLE, mem_o_bus_err pulses 1 cycle, mem_o_ce=0, no register write.
  - Ack in the same cycle as expiry wins; no error is raised.
- Flush:
  - Affects only the capture decision in IDLE.
  - An open BUSY/HOLD transaction is older than the flushing branch and completes normally.
- Downstream stall:
  - With mem_i_stall=1, mem_o_ce/data/we_rd hold their values.
  - Pulses (misaligned, bus_err) are still single-cycle.
- Reset mid-transaction:
  - Returns to IDLE with req=0 on the next edge.
  - A later stray ack is ignored.

Decomposition:
- header.vh additions:
  - funct3 size encodings: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - Memory state encodings: IDLE/BUSY/HOLD.
  - Reuse the existing LOAD_WORD/STORE_WORD opcodes.
- Sub-module mem_lane_align, purely combinational:
  - Inputs: funct3, addr[1:0], rs2, rdata.
  - Outputs: byte_en, wdata, load_ext, misaligned.

Test Plan:
- Reset, then ITYPE with alu_value=0x00000055, wb_en=1, rd=3 → next cycle ce=1, data_rd=0x55, we_rd=1, stall=0.
- LB at addr 0x103, ack 2 cycles after req, rdata=0x80AABBCC → byte_en=1111, addr=0x100, stall high 3 cycles, then data_rd=0xFFFFFF80, we_rd=1.
- SH at addr 0x202, rs2=0x1234ABCD, immediate ack → wr=1, byte_en=1100, wdata=0xABCDABCD, ce=1, we_rd=0.
- LW at addr 0x006 → no req, misaligned pulse 1 cycle, ce=0; then SW at 0x008 with no ack for 16 cycles → bus_err pulse, req=0, stall=0, ce=0.
- LHU at 0x010 with mem_i_stall=1 during ack, rdata=0x0000F00D, stall released 3 cycles later → HOLD, req drops, then data_rd=0x0000F00D one cycle after release.
- flush=1 with ce=1 in IDLE → no capture; flush asserted during BUSY → transaction completes and result is written.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared encodings for the memory-access stage: opcodes, funct3 sizes, FSM states.
// No logic here; constants and types only.
// Imported by memory_access and mem_lane_align.
package memory_access_pkg;

   localparam int OPCODE_WIDTH = 7;

   // Opcodes seen by this stage
   localparam logic [OPCODE_WIDTH-1:0] LOAD_WORD  = 7'b0000011;
   localparam logic [OPCODE_WIDTH-1:0] STORE_WORD = 7'b0100011;
   localparam logic [OPCODE_WIDTH-1:0] ITYPE      = 7'b0010011;

   // funct3 access size / sign encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Bus transaction states
   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_HOLD = 2'd2
   } mem_state_t;

   // Decoded access width
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select + extension for loads; flags misalignment.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module mem_lane_align
   import memory_access_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        wr,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic        misaligned
);

   access_size_t size;
   logic         sign;
   logic [7:0]   lane_b;
   logic [15:0]  lane_h;

   // Decode size and signedness; unsigned variants exist only for loads, anything unknown is a word
   always_comb begin
      size = SZ_WORD;
      sign = 1'b0;
      case (funct3)
         F3_LB:  begin size = SZ_BYTE; sign = 1'b1; end
         F3_LH:  begin size = SZ_HALF; sign = 1'b1; end
         F3_LBU: if (!wr) size = SZ_BYTE;
         F3_LHU: if (!wr) size = SZ_HALF;
         default: size = SZ_WORD;
      endcase
   end

   // Lane select from the returned word
   always_comb begin
      lane_b = rdata[7:0];
      case (addr_lo)
         2'd0: lane_b = rdata[7:0];
         2'd1: lane_b = rdata[15:8];
         2'd2: lane_b = rdata[23:16];
         2'd3: lane_b = rdata[31:24];
         default: lane_b = rdata[7:0];
      endcase
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Store lane steering, load extension and alignment check
   always_comb begin
      byte_en    = 4'b1111;
      wdata      = rs2;
      load_ext   = rdata;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            if (wr) begin
               byte_en = 4'b0001 << addr_lo;
               wdata   = {4{rs2[7:0]}};
            end
            load_ext = sign ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
         end
         SZ_HALF: begin
            if (wr) begin
               byte_en = 4'b0011 << {addr_lo[1], 1'b0};
               wdata   = {2{rs2[15:0]}};
            end
            load_ext   = sign ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
            misaligned = addr_lo[0];
         end
         default: begin
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: issues loads/stores on a single-outstanding req/ack bus, passes other ops through.
// Latency: non-memory ops 1 cycle; memory ops 1 cycle after ack (or 1 cycle after writeback stall clears).
// Backpressure: mem_o_stall holds execute while a transaction is open; mem_i_stall freezes the result.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 5,
   parameter int FUNCT_WIDTH = 3,
   parameter int TIMEOUT     = 16
)(
   input  logic                    mem_clk,
   input  logic                    mem_rst,
   input  logic                    mem_i_ce,
   input  logic [OPCODE_WIDTH-1:0] mem_i_opcode,
   input  logic [FUNCT_WIDTH-1:0]  mem_i_funct3,
   input  logic [DWIDTH-1:0]       mem_i_alu_value,
   input  logic [DWIDTH-1:0]       mem_i_data_rs2,
   input  logic [AWIDTH-1:0]       mem_i_addr_rd,
   input  logic                    mem_i_wb_en,
   input  logic                    mem_i_flush,
   input  logic                    mem_i_stall,
   output logic                    mem_o_stall,
   output logic                    mem_o_req,
   output logic                    mem_o_wr,
   output logic [DWIDTH-1:0]       mem_o_addr,
   output logic [DWIDTH-1:0]       mem_o_wdata,
   output logic [3:0]              mem_o_byte_en,
   input  logic                    mem_i_ack,
   input  logic [DWIDTH-1:0]       mem_i_rdata,
   output logic                    mem_o_ce,
   output logic [AWIDTH-1:0]       mem_o_addr_rd,
   output logic [DWIDTH-1:0]       mem_o_data_rd,
   output logic                    mem_o_we_rd,
   output logic                    mem_o_misaligned,
   output logic                    mem_o_bus_err
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   mem_state_t             state;
   logic [7:0]             tmo_cnt;
   logic                   is_load;
   logic [FUNCT_WIDTH-1:0] funct3_q;
   logic [1:0]             addr_lo_q;
   logic [AWIDTH-1:0]      rd_q;
   logic [DWIDTH-1:0]      hold_data;

   logic                   capture;
   logic                   is_store_in;
   logic                   is_mem_in;
   logic [FUNCT_WIDTH-1:0] al_funct3;
   logic [1:0]             al_addr_lo;
   logic                   al_wr;
   logic [3:0]             al_byte_en;
   logic [DWIDTH-1:0]      al_wdata;
   logic [DWIDTH-1:0]      al_load_ext;
   logic                   al_misaligned;

   assign mem_o_stall = (state != MEM_IDLE);
   assign is_store_in = (mem_i_opcode == STORE_WORD);
   assign is_mem_in   = (mem_i_opcode == LOAD_WORD) || is_store_in;
   assign capture     = (state == MEM_IDLE) && mem_i_ce && !mem_i_flush && !mem_i_stall;

   // Aligner sees the incoming op while idle and the latched op while a transaction is open
   always_comb begin
      al_funct3  = mem_i_funct3;
      al_addr_lo = mem_i_alu_value[1:0];
      al_wr      = is_store_in;
      if (state != MEM_IDLE) begin
         al_funct3  = funct3_q;
         al_addr_lo = addr_lo_q;
         al_wr      = !is_load;
      end
   end

   mem_lane_align u_align (
      .funct3     (al_funct3),
      .addr_lo    (al_addr_lo),
      .wr         (al_wr),
      .rs2        (mem_i_data_rs2),
      .rdata      (mem_i_rdata),
      .byte_en    (al_byte_en),
      .wdata      (al_wdata),
      .load_ext   (al_load_ext),
      .misaligned (al_misaligned)
   );

   // Transaction FSM with all outputs registered
   always_ff @(posedge mem_clk) begin
      if (mem_rst) begin
         state            <= MEM_IDLE;
         tmo_cnt          <= 8'd0;
         is_load          <= 1'b0;
         funct3_q         <= '0;
         addr_lo_q        <= 2'b00;
         rd_q             <= '0;
         hold_data        <= '0;
         mem_o_req        <= 1'b0;
         mem_o_wr         <= 1'b0;
         mem_o_addr       <= '0;
         mem_o_wdata      <= '0;
         mem_o_byte_en    <= 4'b0000;
         mem_o_ce         <= 1'b0;
         mem_o_addr_rd    <= '0;
         mem_o_data_rd    <= '0;
         mem_o_we_rd      <= 1'b0;
         mem_o_misaligned <= 1'b0;
         mem_o_bus_err    <= 1'b0;
      end else begin
         mem_o_misaligned <= 1'b0;
         mem_o_bus_err    <= 1'b0;
         case (state)
            MEM_IDLE: begin
               if (capture) begin
                  if (!is_mem_in) begin
                     mem_o_ce      <= 1'b1;
                     mem_o_addr_rd <= mem_i_addr_rd;
                     mem_o_data_rd <= mem_i_alu_value;
                     mem_o_we_rd   <= mem_i_wb_en;
                  end else if (al_misaligned) begin
                     mem_o_misaligned <= 1'b1;
                     mem_o_ce         <= 1'b0;
                  end else begin
                     state         <= MEM_BUSY;
                     tmo_cnt       <= 8'd0;
                     is_load       <= !is_store_in;
                     funct3_q      <= mem_i_funct3;
                     addr_lo_q     <= mem_i_alu_value[1:0];
                     rd_q          <= mem_i_addr_rd;
                     mem_o_req     <= 1'b1;
                     mem_o_wr      <= is_store_in;
                     mem_o_addr    <= {mem_i_alu_value[DWIDTH-1:2], 2'b00};
                     mem_o_wdata   <= al_wdata;
                     mem_o_byte_en <= al_byte_en;
                     mem_o_ce      <= 1'b0;
                  end
               end else if (!mem_i_stall) begin
                  mem_o_ce <= 1'b0;
               end
            end
            MEM_BUSY: begin
               if (mem_i_ack && mem_o_req) begin
                  mem_o_req <= 1'b0;
                  tmo_cnt   <= 8'd0;
                  if (mem_i_stall) begin
                     state     <= MEM_HOLD;
                     hold_data <= al_load_ext;
                  end else begin
                     state         <= MEM_IDLE;
                     mem_o_ce      <= 1'b1;
                     mem_o_addr_rd <= rd_q;
                     mem_o_we_rd   <= is_load;
                     if (is_load) mem_o_data_rd <= al_load_ext;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state         <= MEM_IDLE;
                  tmo_cnt       <= 8'd0;
                  mem_o_req     <= 1'b0;
                  mem_o_bus_err <= 1'b1;
                  mem_o_ce      <= 1'b0;
                  mem_o_we_rd   <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            MEM_HOLD: begin
               if (!mem_i_stall) begin
                  state         <= MEM_IDLE;
                  mem_o_ce      <= 1'b1;
                  mem_o_addr_rd <= rd_q;
                  mem_o_we_rd   <= is_load;
                  if (is_load) mem_o_data_rd <= hold_data;
               end
            end
            default: state <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized transactions.
// Expected values come from a behavioural model of lane selection and extension.
// Ack delay and writeback stall are randomized to exercise BUSY and HOLD.
module tb_memory_access;
   import memory_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce_in, flush, stall_in, ack, wb_en;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] alu, rs2, rdata;
   logic [4:0]  rd;
   logic        o_stall, o_req, o_wr, o_ce, o_we_rd, o_mis, o_berr;
   logic [31:0] o_addr, o_wdata, o_data_rd;
   logic [3:0]  o_be;
   logic [4:0]  o_addr_rd;

   int n_tests = 0;
   int n_fail  = 0;

   memory_access dut (
      .mem_clk(clk), .mem_rst(rst), .mem_i_ce(ce_in), .mem_i_opcode(opcode),
      .mem_i_funct3(funct3), .mem_i_alu_value(alu), .mem_i_data_rs2(rs2),
      .mem_i_addr_rd(rd), .mem_i_wb_en(wb_en), .mem_i_flush(flush),
      .mem_i_stall(stall_in), .mem_o_stall(o_stall), .mem_o_req(o_req),
      .mem_o_wr(o_wr), .mem_o_addr(o_addr), .mem_o_wdata(o_wdata),
      .mem_o_byte_en(o_be), .mem_i_ack(ack), .mem_i_rdata(rdata),
      .mem_o_ce(o_ce), .mem_o_addr_rd(o_addr_rd), .mem_o_data_rd(o_data_rd),
      .mem_o_we_rd(o_we_rd), .mem_o_misaligned(o_mis), .mem_o_bus_err(o_berr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r, input logic w);
      ce_in = 1'b1; opcode = op; funct3 = f3; alu = a; rs2 = d; rd = r; wb_en = w;
      tick();
      ce_in = 1'b0;
   endtask

   // Reference: pick the addressed byte/half of the returned word and extend it
   function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] w);
      logic [31:0] v;
      case (f3)
         0, 4: begin
            v = (w >> (8 * a)) & 32'hFF;
            if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
         end
         1, 5: begin
            v = (w >> (16 * (a / 2))) & 32'hFFFF;
            if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1; ce_in = 0; flush = 0; stall_in = 0; ack = 0; wb_en = 0;
      opcode = '0; funct3 = '0; alu = '0; rs2 = '0; rd = '0; rdata = '0;
      tick(); tick();
      n_tests++;
      if ({o_stall, o_req, o_wr, o_addr, o_wdata, o_be, o_ce, o_addr_rd, o_data_rd, o_we_rd, o_mis, o_berr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: stall=%0b req=%0b ce=%0b data=%h be=%b, required all zero",
                  o_stall, o_req, o_ce, o_data_rd, o_be);
      end
      rst = 1'b0;
   endtask

   task automatic test_nonmem();
      issue(ITYPE, 3'd0, 32'h55, 32'h0, 5'd3, 1'b1);
      n_tests++;
      if ({o_ce, o_data_rd, o_we_rd, o_stall, o_addr_rd} !== {1'b1, 32'h55, 1'b1, 1'b0, 5'd3}) begin
         n_fail++;
         $display("FAIL nonmem_pass: ce=%0b data=%h we=%0b stall=%0b rd=%0d, required 1 00000055 1 0 3",
                  o_ce, o_data_rd, o_we_rd, o_stall, o_addr_rd);
      end
      tick();
      n_tests++;
      if (o_ce !== 1'b0) begin
         n_fail++; $display("FAIL nonmem_ce_drop: ce=%0b, required 0", o_ce);
      end
   endtask

   task automatic test_load_lb();
      int stall_hi = 0;
      issue(LOAD_WORD, F3_LB, 32'h103, 32'h0, 5'd7, 1'b0);
      n_tests++;
      if ({o_req, o_wr, o_addr, o_be, o_ce} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b0}) begin
         n_fail++;
         $display("FAIL lb_request: req=%0b wr=%0b addr=%h be=%b ce=%0b, required 1 0 00000100 1111 0",
                  o_req, o_wr, o_addr, o_be, o_ce);
      end
      for (int i = 0; i < 3; i++) begin
         if (o_stall) stall_hi++;
         if (i == 2) begin ack = 1'b1; rdata = 32'h80AABBCC; end
         tick();
      end
      ack = 1'b0;
      n_tests++;
      if (stall_hi != 3 || o_stall !== 1'b0) begin
         n_fail++; $display("FAIL lb_stall_cycles: high=%0d now=%0b, required 3 then 0", stall_hi, o_stall);
      end
      n_tests++;
      if ({o_ce, o_data_rd, o_we_rd, o_req, o_addr_rd} !== {1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 5'd7}) begin
         n_fail++;
         $display("FAIL lb_result: ce=%0b data=%h we=%0b req=%0b rd=%0d, required 1 ffffff80 1 0 7",
                  o_ce, o_data_rd, o_we_rd, o_req, o_addr_rd);
      end
   endtask

   task automatic test_store_sh();
      issue(STORE_WORD, F3_SH, 32'h202, 32'h1234ABCD, 5'd0, 1'b0);
      n_tests++;
      if ({o_req, o_wr, o_addr, o_be, o_wdata} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD}) begin
         n_fail++;
         $display("FAIL sh_request: req=%0b wr=%0b addr=%h be=%b wdata=%h, required 1 1 00000200 1100 abcdabcd",
                  o_req, o_wr, o_addr, o_be, o_wdata);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_tests++;
      if ({o_ce, o_we_rd, o_data_rd, o_req, o_stall} !== {1'b1, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL sh_result: ce=%0b we=%0b data=%h req=%0b stall=%0b, required 1 0 ffffff80 0 0",
                  o_ce, o_we_rd, o_data_rd, o_req, o_stall);
      end
   endtask

   task automatic test_misaligned_timeout();
      int hi = 0;
      issue(LOAD_WORD, F3_LW, 32'h006, 32'h0, 5'd1, 1'b0);
      n_tests++;
      if ({o_mis, o_req, o_ce, o_stall} !== 4'b1000) begin
         n_fail++;
         $display("FAIL misaligned_pulse: mis=%0b req=%0b ce=%0b stall=%0b, required 1 0 0 0", o_mis, o_req, o_ce, o_stall);
      end
      tick();
      n_tests++;
      if (o_mis !== 1'b0) begin
         n_fail++; $display("FAIL misaligned_width: mis=%0b, required 0", o_mis);
      end
      issue(STORE_WORD, F3_SW, 32'h008, 32'hCAFEF00D, 5'd2, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (!o_req) break;
         if (o_berr) hi = 100;
         hi++;
         tick();
      end
      n_tests++;
      if (hi != 16) begin
         n_fail++; $display("FAIL timeout_req_cycles: req high %0d cycles, required 16", hi);
      end
      n_tests++;
      if ({o_berr, o_req, o_stall, o_ce} !== 4'b1000) begin
         n_fail++;
         $display("FAIL timeout_abort: berr=%0b req=%0b stall=%0b ce=%0b, required 1 0 0 0", o_berr, o_req, o_stall, o_ce);
      end
      tick();
      n_tests++;
      if (o_berr !== 1'b0) begin
         n_fail++; $display("FAIL timeout_pulse_width: berr=%0b, required 0", o_berr);
      end
   endtask

   task automatic test_hold();
      issue(LOAD_WORD, F3_LHU, 32'h010, 32'h0, 5'd9, 1'b0);
      ack = 1'b1; stall_in = 1'b1; rdata = 32'h0000F00D;
      tick();
      ack = 1'b0;
      n_tests++;
      if ({o_req, o_stall, o_ce} !== 3'b010) begin
         n_fail++; $display("FAIL hold_enter: req=%0b stall=%0b ce=%0b, required 0 1 0", o_req, o_stall, o_ce);
      end
      rdata = 32'h12345678;
      tick(); tick();
      n_tests++;
      if ({o_stall, o_ce} !== 2'b10) begin
         n_fail++; $display("FAIL hold_wait: stall=%0b ce=%0b, required 1 0", o_stall, o_ce);
      end
      stall_in = 1'b0;
      tick();
      n_tests++;
      if ({o_ce, o_data_rd, o_we_rd, o_stall, o_addr_rd} !== {1'b1, 32'h0000F00D, 1'b1, 1'b0, 5'd9}) begin
         n_fail++;
         $display("FAIL hold_result: ce=%0b data=%h we=%0b stall=%0b rd=%0d, required 1 0000f00d 1 0 9",
                  o_ce, o_data_rd, o_we_rd, o_stall, o_addr_rd);
      end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      issue(ITYPE, 3'd0, 32'h77, 32'h0, 5'd4, 1'b1);
      n_tests++;
      if ({o_ce, o_data_rd} !== {1'b0, 32'h0000F00D}) begin
         n_fail++; $display("FAIL flush_idle: ce=%0b data=%h, required 0 0000f00d", o_ce, o_data_rd);
      end
      flush = 1'b0;
      issue(LOAD_WORD, F3_LW, 32'h020, 32'h0, 5'd5, 1'b0);
      flush = 1'b1; ce_in = 1'b1; opcode = ITYPE;
      tick();
      ack = 1'b1; rdata = 32'hDEADBEEF;
      tick();
      ack = 1'b0; ce_in = 1'b0; flush = 1'b0;
      n_tests++;
      if ({o_ce, o_data_rd, o_we_rd, o_addr_rd} !== {1'b1, 32'hDEADBEEF, 1'b1, 5'd5}) begin
         n_fail++;
         $display("FAIL flush_busy_completes: ce=%0b data=%h we=%0b rd=%0d, required 1 deadbeef 1 5",
                  o_ce, o_data_rd, o_we_rd, o_addr_rd);
      end
   endtask

   task automatic test_reset_mid();
      issue(LOAD_WORD, F3_LW, 32'h040, 32'h0, 5'd6, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({o_req, o_stall} !== 2'b00) begin
         n_fail++; $display("FAIL reset_mid: req=%0b stall=%0b, required 0 0", o_req, o_stall);
      end
      ack = 1'b1; rdata = 32'hFFFFFFFF;
      tick();
      ack = 1'b0;
      n_tests++;
      if ({o_ce, o_req, o_stall, o_data_rd} !== {3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL stray_ack: ce=%0b req=%0b stall=%0b data=%h, required 0 0 0 00000000", o_ce, o_req, o_stall, o_data_rd);
      end
   endtask

   task automatic test_random();
      int          ld_f3[5] = '{0, 1, 2, 4, 5};
      int          kind, f3, a, bytes, s;
      logic        is_st, mis, w;
      logic [31:0] addr, d, rw, exp_data, exp_wd;
      logic [3:0]  exp_be;
      logic [4:0]  r;
      rst = 1'b1; tick(); rst = 1'b0;
      exp_data = 32'h0;
      for (int t = 0; t < 80; t++) begin
         kind = $urandom_range(0, 2);
         addr = $urandom; d = $urandom; r = 5'($urandom); w = 1'($urandom);
         a = int'(addr[1:0]);
         if (kind == 0) begin
            issue(ITYPE, 3'd0, addr, d, r, w);
            exp_data = addr;
            n_tests++;
            if ({o_ce, o_data_rd, o_we_rd, o_addr_rd} !== {1'b1, exp_data, w, r}) begin
               n_fail++;
               $display("FAIL rand_nonmem[%0d]: ce=%0b data=%h we=%0b rd=%0d, required 1 %h %0b %0d",
                        t, o_ce, o_data_rd, o_we_rd, o_addr_rd, exp_data, w, r);
            end
         end else begin
            is_st = (kind == 2);
            f3    = is_st ? $urandom_range(0, 2) : ld_f3[$urandom_range(0, 4)];
            bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
            mis   = (bytes == 2 && (a % 2) != 0) || (bytes == 4 && a != 0);
            exp_be = 4'hF;
            if (is_st && bytes == 1) exp_be = 4'(1 << a);
            if (is_st && bytes == 2) exp_be = 4'(3 << (a & 2));
            exp_wd = (bytes == 1) ? 32'(d[7:0]) * 32'h01010101 :
                     (bytes == 2) ? 32'(d[15:0]) * 32'h00010001 : d;
            issue(is_st ? STORE_WORD : LOAD_WORD, 3'(f3), addr, d, r, 1'b0);
            if (mis) begin
               n_tests++;
               if ({o_mis, o_req, o_ce, o_stall} !== 4'b1000) begin
                  n_fail++;
                  $display("FAIL rand_misaligned[%0d]: f3=%0d a=%0d mis=%0b req=%0b ce=%0b, required 1 0 0",
                           t, f3, a, o_mis, o_req, o_ce);
               end
               tick();
               continue;
            end
            n_tests++;
            if ({o_req, o_wr, o_addr, o_be} !== {1'b1, is_st, addr & 32'hFFFFFFFC, exp_be} ||
                (is_st && o_wdata !== exp_wd)) begin
               n_fail++;
               $display("FAIL rand_request[%0d]: req=%0b wr=%0b addr=%h be=%b wdata=%h, required 1 %0b %h %b %h",
                        t, o_req, o_wr, o_addr, o_be, o_wdata, is_st, addr & 32'hFFFFFFFC, exp_be, exp_wd);
            end
            repeat ($urandom_range(0, 4)) tick();
            s = $urandom_range(0, 1);
            rw = $urandom;
            ack = 1'b1; stall_in = 1'(s); rdata = rw;
            tick();
            ack = 1'b0; rdata = $urandom;
            if (s != 0) begin
               n_tests++;
               if ({o_req, o_stall, o_ce} !== 3'b010) begin
                  n_fail++;
                  $display("FAIL rand_hold[%0d]: req=%0b stall=%0b ce=%0b, required 0 1 0", t, o_req, o_stall, o_ce);
               end
               repeat ($urandom_range(0, 3)) tick();
               stall_in = 1'b0;
               tick();
            end
            if (!is_st) exp_data = ref_load(f3, a, rw);
            n_tests++;
            if ({o_ce, o_we_rd, o_data_rd, o_addr_rd, o_stall} !== {1'b1, !is_st, exp_data, r, 1'b0}) begin
               n_fail++;
               $display("FAIL rand_result[%0d]: f3=%0d a=%0d ce=%0b we=%0b data=%h rd=%0d, required 1 %0b %h %0d",
                        t, f3, a, o_ce, o_we_rd, o_data_rd, o_addr_rd, !is_st, exp_data, r);
            end
         end
         if ($urandom_range(0, 1) != 0) begin
            stall_in = 1'b1; ce_in = 1'b1; opcode = ITYPE; alu = $urandom;
            tick();
            stall_in = 1'b0; ce_in = 1'b0;
            n_tests++;
            if ({o_ce, o_data_rd} !== {1'b1, exp_data}) begin
               n_fail++;
               $display("FAIL rand_wb_stall[%0d]: ce=%0b data=%h, required 1 %h", t, o_ce, o_data_rd, exp_data);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_load_lb();
      test_store_sh();
      test_misaligned_timeout();
      test_hold();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
